// File: rtl/ddr_phase_ctrl.sv
// Phase-shift controller for up to four DCMs sharing one upstream synthesiser.
// Sequences DCM reset/lock bring-up, then steps one channel at a time towards a commanded position.
module ddr_phase_ctrl #(
   parameter int CHANNELS     = 2,
   parameter int POS_WIDTH    = 9,
   parameter int PS_MAX       = 255,
   parameter int DONE_TIMEOUT = 64,
   parameter int RST_DELAY    = 15,
   localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            fx_locked,
   input  logic [CHANNELS-1:0]             dcm_locked,
   input  logic [CHANNELS-1:0]             psdone,
   output logic [CHANNELS-1:0]             dcm_rst,
   output logic [CHANNELS-1:0]             psen,
   output logic [CHANNELS-1:0]             psincdec,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [CHAN_W-1:0]               cmd_chan,
   input  logic [1:0]                      cmd_mode,
   input  logic signed [POS_WIDTH-1:0]     cmd_target,
   output logic [CHANNELS*POS_WIDTH-1:0]   cur_pos,
   output logic                            busy,
   output logic                            err_limit,
   output logic                            err_timeout,
   output logic                            locked
);

   localparam int DLY_W = $clog2(RST_DELAY + 1);
   localparam int TO_W  = $clog2(DONE_TIMEOUT + 1);
   localparam logic signed [POS_WIDTH-1:0] PMAX = POS_WIDTH'(PS_MAX);
   localparam logic signed [POS_WIDTH-1:0] NMAX = -PMAX;

   typedef enum logic [2:0] {RSTHOLD, RSTDLY, LOCKWAIT, IDLE, PULSE, WAITDONE} state_e;

   state_e                       state_q, state_d;
   logic [DLY_W-1:0]             dly_q, dly_d;
   logic [TO_W-1:0]              to_q, to_d;
   logic [CHAN_W-1:0]            chan_q, chan_d;
   logic signed [POS_WIDTH-1:0]  tgt_q, tgt_d;
   logic signed [POS_WIDTH-1:0]  pos_q [CHANNELS];
   logic signed [POS_WIDTH-1:0]  pos_d [CHANNELS];
   logic [CHANNELS-1:0]          dir_q, dir_d;
   logic                         errLim_q, errLim_d;
   logic                         errTo_q, errTo_d;
   logic                         locked_q, locked_d;

   logic signed [POS_WIDTH-1:0]  curPos, cmdPos, cmdTgt, stepPos;
   logic                         curDone, cmdChanOk, cmdLim, lockOk;

   assign lockOk = fx_locked & (&dcm_locked);

   // Channel selection: an out-of-range cmd_chan reads as position 0 and becomes a no-op.
   always_comb begin
      curPos    = '0;
      cmdPos    = '0;
      curDone   = 1'b0;
      cmdChanOk = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (CHAN_W'(c) == chan_q) begin
            curPos  = pos_q[c];
            curDone = psdone[c];
         end
         if (CHAN_W'(c) == cmd_chan) begin
            cmdPos    = pos_q[c];
            cmdChanOk = 1'b1;
         end
      end
      stepPos = (tgt_q > curPos) ? curPos + POS_WIDTH'(1) : curPos - POS_WIDTH'(1);
   end

   // An out-of-range relative step keeps the current position as target, so no psen is issued.
   always_comb begin
      cmdTgt = cmdPos;
      cmdLim = 1'b0;
      case (cmd_mode)
         2'b00: if (cmdPos == PMAX) cmdLim = 1'b1; else cmdTgt = cmdPos + POS_WIDTH'(1);
         2'b01: if (cmdPos == NMAX) cmdLim = 1'b1; else cmdTgt = cmdPos - POS_WIDTH'(1);
         2'b10: begin
            if (cmd_target > PMAX) begin
               cmdTgt = PMAX;
               cmdLim = 1'b1;
            end else if (cmd_target < NMAX) begin
               cmdTgt = NMAX;
               cmdLim = 1'b1;
            end else begin
               cmdTgt = cmd_target;
            end
         end
         default: cmdTgt = '0;
      endcase
      if (!cmdChanOk) begin
         cmdTgt = cmdPos;
         cmdLim = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      dly_d    = dly_q;
      to_d     = to_q;
      chan_d   = chan_q;
      tgt_d    = tgt_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      errLim_d = 1'b0;
      errTo_d  = errTo_q;
      case (state_q)
         RSTHOLD: begin
            dly_d = '0;
            if (fx_locked) state_d = RSTDLY;
         end
         RSTDLY: begin
            if (dly_q == DLY_W'(RST_DELAY - 1)) begin
               dly_d   = '0;
               state_d = LOCKWAIT;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         LOCKWAIT: if (&dcm_locked) state_d = IDLE;
         IDLE: begin
            if (cmd_valid) begin
               chan_d   = cmd_chan;
               tgt_d    = cmdTgt;
               errLim_d = cmdLim;
               state_d  = PULSE;
               if (cmd_mode == 2'b11) errTo_d = 1'b0;
               for (int c = 0; c < CHANNELS; c++)
                  if ((CHAN_W'(c) == cmd_chan) && (cmdTgt != cmdPos)) dir_d[c] = (cmdTgt > cmdPos);
            end
         end
         PULSE: begin
            to_d    = '0;
            state_d = (tgt_q == curPos) ? IDLE : WAITDONE;
         end
         WAITDONE: begin
            if (curDone) begin
               for (int c = 0; c < CHANNELS; c++)
                  if (CHAN_W'(c) == chan_q) pos_d[c] = stepPos;
               state_d = (stepPos == tgt_q) ? IDLE : PULSE;
            end else if (to_q == TO_W'(DONE_TIMEOUT - 1)) begin
               errTo_d = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         default: state_d = RSTHOLD;
      endcase
      // Losing any lock while operational discards positions and any command in flight.
      if (((state_q == IDLE) || (state_q == PULSE) || (state_q == WAITDONE)) && !lockOk) begin
         state_d  = RSTHOLD;
         dly_d    = '0;
         to_d     = '0;
         errLim_d = 1'b0;
         errTo_d  = errTo_q;
         for (int c = 0; c < CHANNELS; c++) pos_d[c] = '0;
      end
      locked_d = (state_d == IDLE) || (state_d == PULSE) || (state_d == WAITDONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RSTHOLD;
         dly_q    <= '0;
         to_q     <= '0;
         chan_q   <= '0;
         tgt_q    <= '0;
         dir_q    <= '0;
         errLim_q <= 1'b0;
         errTo_q  <= 1'b0;
         locked_q <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) pos_q[c] <= '0;
      end else begin
         state_q  <= state_d;
         dly_q    <= dly_d;
         to_q     <= to_d;
         chan_q   <= chan_d;
         tgt_q    <= tgt_d;
         dir_q    <= dir_d;
         errLim_q <= errLim_d;
         errTo_q  <= errTo_d;
         locked_q <= locked_d;
         for (int c = 0; c < CHANNELS; c++) pos_q[c] <= pos_d[c];
      end
   end

   always_comb begin
      psen    = '0;
      cur_pos = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         psen[c] = (state_q == PULSE) && (CHAN_W'(c) == chan_q) && (tgt_q != curPos);
         cur_pos[c*POS_WIDTH +: POS_WIDTH] = pos_q[c];
      end
   end

   assign dcm_rst     = {CHANNELS{(state_q == RSTHOLD) || (state_q == RSTDLY)}};
   assign psincdec    = dir_q;
   assign cmd_ready   = (state_q == IDLE) && lockOk;
   assign busy        = (state_q == PULSE) || (state_q == WAITDONE);
   assign err_limit   = errLim_q;
   assign err_timeout = errTo_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_ddr_phase_ctrl.sv
// Self-checking bench for ddr_phase_ctrl: directed bring-up, limit, timeout, lock-loss and
// async-reset scenarios plus randomized commands checked against a position-level model.
module tb_ddr_phase_ctrl;

   localparam int CH  = 2;
   localparam int PW  = 9;
   localparam int PSM = 255;
   localparam int DT  = 64;
   localparam int RD  = 15;

   logic                 clk;
   logic                 reset;
   logic                 fx_locked;
   logic [CH-1:0]        dcm_locked;
   logic [CH-1:0]        psdone;
   logic [CH-1:0]        dcm_rst;
   logic [CH-1:0]        psen;
   logic [CH-1:0]        psincdec;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [0:0]           cmd_chan;
   logic [1:0]           cmd_mode;
   logic signed [PW-1:0] cmd_target;
   logic [CH*PW-1:0]     cur_pos;
   logic                 busy;
   logic                 err_limit;
   logic                 err_timeout;
   logic                 locked;

   int  total = 0;
   int  bad   = 0;
   int  modelPos [CH];
   bit  modelErrTo;
   bit  respOn    = 1'b0;
   int  respDelay = 4;
   int  psenCnt [CH];
   int  upCnt [CH];

   ddr_phase_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .fx_locked   (fx_locked),
      .dcm_locked  (dcm_locked),
      .psdone      (psdone),
      .dcm_rst     (dcm_rst),
      .psen        (psen),
      .psincdec    (psincdec),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_chan    (cmd_chan),
      .cmd_mode    (cmd_mode),
      .cmd_target  (cmd_target),
      .cur_pos     (cur_pos),
      .busy        (busy),
      .err_limit   (err_limit),
      .err_timeout (err_timeout),
      .locked      (locked)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DCM stand-in: answers each psen with psdone respDelay cycles later.
   initial begin
      logic [CH-1:0] pend;
      psdone = '0;
      forever begin
         if (respOn && ((|psen) === 1'b1)) begin
            pend = psen;
            repeat (respDelay) @(posedge clk);
            #2 psdone = pend;
            @(posedge clk);
            #2 psdone = '0;
         end else begin
            @(posedge clk);
            #2;
         end
      end
   end

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (psen[c] === 1'b1) begin
            psenCnt[c]++;
            if (psincdec[c] === 1'b1) upCnt[c]++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int posOf(input int c);
      logic signed [PW-1:0] v;
      v = cur_pos[c*PW +: PW];
      return int'(v);
   endfunction

   task automatic waitRstFall(input string tag);
      int n = 0;
      while ((dcm_rst !== 2'b00) && (n < 40)) begin
         tick();
         n++;
      end
      checkOutput(tag, n, RD + 1);
   endtask

   task automatic applyStimulus(input int ch, input int mode, input int target, input int dly);
      int startPos, tgt, steps, n, budget;
      bit lim;
      int psen0 [CH];
      int up0 [CH];
      startPos = modelPos[ch];
      case (mode)
         0:       tgt = startPos + 1;
         1:       tgt = startPos - 1;
         2:       tgt = target;
         default: tgt = 0;
      endcase
      lim = 1'b0;
      if (tgt > PSM) begin
         lim = 1'b1;
         tgt = (mode == 2) ? PSM : startPos;
      end else if (tgt < -PSM) begin
         lim = 1'b1;
         tgt = (mode == 2) ? -PSM : startPos;
      end
      steps  = (tgt > startPos) ? tgt - startPos : startPos - tgt;
      budget = (steps + 1) * (dly + 3) + 10;
      for (int c = 0; c < CH; c++) begin
         psen0[c] = psenCnt[c];
         up0[c]   = upCnt[c];
      end
      respDelay  = dly;
      cmd_chan   = ch[0];
      cmd_mode   = 2'(mode);
      cmd_target = PW'(target);
      cmd_valid  = 1'b1;
      tick();
      cmd_valid = 1'b0;
      if (mode == 3) modelErrTo = 1'b0;
      checkOutput("busyAfterAccept", busy, 1);
      checkOutput("errLimit", err_limit, lim);
      n = 0;
      while ((busy === 1'b1) && (n < budget)) begin
         tick();
         n++;
         if (n == 1) checkOutput("errLimitOneCycle", err_limit, 0);
      end
      checkOutput("busyDone", busy, 0);
      if (steps == 0) checkOutput("busyOneCycle", n, 1);
      modelPos[ch] = tgt;
      for (int c = 0; c < CH; c++) begin
         checkOutput($sformatf("pos%0d", c), posOf(c), modelPos[c]);
         checkOutput($sformatf("psenCount%0d", c), psenCnt[c] - psen0[c], (c == ch) ? steps : 0);
         checkOutput($sformatf("upCount%0d", c), upCnt[c] - up0[c], ((c == ch) && (tgt > startPos)) ? steps : 0);
      end
      checkOutput("readyAfter", cmd_ready, 1);
      checkOutput("errTimeoutAfter", err_timeout, modelErrTo);
   endtask

   initial begin
      int p, tgtv, m, ch, mode, tv, dl;
      reset      = 1'b1;
      fx_locked  = 1'b0;
      dcm_locked = '0;
      cmd_valid  = 1'b0;
      cmd_chan   = '0;
      cmd_mode   = '0;
      cmd_target = '0;
      modelErrTo = 1'b0;
      for (int c = 0; c < CH; c++) modelPos[c] = 0;
      #3;
      checkOutput("rstDcmRst", dcm_rst, 2'b11);
      checkOutput("rstPsen", psen, 0);
      checkOutput("rstPsincdec", psincdec, 0);
      checkOutput("rstReady", cmd_ready, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstLocked", locked, 0);
      checkOutput("rstErrLim", err_limit, 0);
      checkOutput("rstErrTo", err_timeout, 0);
      checkOutput("rstCurPos", cur_pos, 0);
      tick();
      tick();
      reset  = 1'b0;
      respOn = 1'b1;

      repeat (4) tick();
      checkOutput("holdNoFx", dcm_rst, 2'b11);
      fx_locked = 1'b1;
      waitRstFall("bringUpRstFall");
      repeat (3) tick();
      checkOutput("lockWaitLocked", locked, 0);
      checkOutput("lockWaitReady", cmd_ready, 0);
      dcm_locked = 2'b11;
      tick();
      checkOutput("bringUpLocked", locked, 1);
      checkOutput("bringUpReady", cmd_ready, 1);

      applyStimulus(1, 2, 3, 4);

      applyStimulus(0, 2, PSM, 1);
      applyStimulus(0, 0, 0, 2);
      applyStimulus(0, 2, -256, 1);
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 3, 0, 1);

      for (int i = 0; i < 12; i++) begin
         ch   = int'($urandom_range(0, CH - 1));
         mode = int'($urandom_range(0, 3));
         tv   = int'($urandom_range(0, 80)) - 40;
         dl   = int'($urandom_range(1, 6));
         applyStimulus(ch, mode, tv, dl);
      end

      respOn = 1'b0;
      p = modelPos[1];
      m = (p < PSM) ? 0 : 1;
      cmd_chan  = 1'b1;
      cmd_mode  = 2'(m);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      checkOutput("toPsen", psen, 2'b10);
      repeat (DT) tick();
      checkOutput("toNotYet", err_timeout, 0);
      checkOutput("toStillBusy", busy, 1);
      tick();
      checkOutput("toSet", err_timeout, 1);
      checkOutput("toBusyOff", busy, 0);
      checkOutput("toReady", cmd_ready, 1);
      checkOutput("toPosKept", posOf(1), p);
      modelErrTo = 1'b1;
      respOn = 1'b1;
      applyStimulus(1, 2, modelPos[1], 2);
      applyStimulus(0, 3, 0, 2);

      respDelay = 8;
      tgtv = (modelPos[1] > 0) ? modelPos[1] - 10 : modelPos[1] + 10;
      cmd_chan   = 1'b1;
      cmd_mode   = 2'b10;
      cmd_target = PW'(tgtv);
      cmd_valid  = 1'b1;
      tick();
      cmd_valid = 1'b0;
      checkOutput("llPsen", psen, 2'b10);
      repeat (3) tick();
      checkOutput("llBusy", busy, 1);
      dcm_locked = 2'b10;
      tick();
      checkOutput("llLocked", locked, 0);
      checkOutput("llDcmRst", dcm_rst, 2'b11);
      checkOutput("llCurPos", cur_pos, 0);
      checkOutput("llBusyOff", busy, 0);
      checkOutput("llReady", cmd_ready, 0);
      checkOutput("llErrLim", err_limit, 0);
      checkOutput("llErrTo", err_timeout, modelErrTo);
      for (int c = 0; c < CH; c++) modelPos[c] = 0;
      dcm_locked = 2'b11;
      waitRstFall("relockRstFall");
      tick();
      checkOutput("relockLocked", locked, 1);

      respDelay  = 3;
      cmd_chan   = 1'b0;
      cmd_mode   = 2'b00;
      cmd_valid  = 1'b1;
      tick();
      cmd_valid = 1'b0;
      checkOutput("arPsenBefore", psen, 2'b01);
      #2 reset = 1'b1;
      #1;
      checkOutput("arPsen", psen, 0);
      checkOutput("arDcmRst", dcm_rst, 2'b11);
      checkOutput("arLocked", locked, 0);
      checkOutput("arBusy", busy, 0);
      checkOutput("arReady", cmd_ready, 0);
      checkOutput("arCurPos", cur_pos, 0);
      checkOutput("arPsincdec", psincdec, 0);
      tick();
      reset = 1'b0;
      modelErrTo = 1'b0;
      for (int c = 0; c < CH; c++) modelPos[c] = 0;
      waitRstFall("arRstFall");
      tick();
      checkOutput("arRelocked", locked, 1);
      applyStimulus(1, 2, -5, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
